// File: rtl/tc_sram_pkg.sv
// Shared types and helpers for the SRAM initiator block.
// Latency: n/a (types and a constant function only).
// Backpressure: n/a.
package tc_sram_pkg;

  // Widest read data the response buffer can carry. Narrower instances
  // zero-extend into it and take the low bits back out.
  localparam int unsigned RspMaxWidth = 64;

  // Address width for a given word count. A single-word SRAM still gets one
  // address bit so every port keeps a legal width.
  function automatic int unsigned addr_width(input int unsigned num_words);
    return (num_words <= 1) ? 1 : unsigned'($clog2(num_words));
  endfunction

  // One buffered read response.
  typedef struct packed {
    logic [RspMaxWidth-1:0] rdata;
    logic                   err;
  } rsp_t;

endpackage

// File: rtl/tc_sram_initiator_fifo.sv
// Fall-through response FIFO: an entry pushed into an empty FIFO is visible on the output that same cycle.
// Latency: 0 cycles when empty, otherwise entries leave in push order.
// Backpressure: out_rdy stalls the head; no push-side backpressure, the producer guarantees space.
// Ports: clk_i/rst_ni clock and async active-low reset; in_vld/in_dat push side;
//        out_vld/out_rdy/out_dat pop side; full reports Depth entries stored.
module tc_sram_initiator_fifo #(
  parameter int unsigned Depth = 2,
  parameter type         T     = logic
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic in_vld,
  input  T     in_dat,
  output logic out_vld,
  input  logic out_rdy,
  output T     out_dat,
  output logic full
);

  localparam int unsigned PtrW = (Depth > 1) ? $clog2(Depth) : 1;
  localparam int unsigned CntW = $clog2(Depth + 1);

  T                mem [Depth];
  logic [PtrW-1:0] wr_ptr_q;
  logic [PtrW-1:0] rd_ptr_q;
  logic [CntW-1:0] cnt_q;
  logic            empty;
  logic            bypass;
  logic            store;
  logic            deq;

  assign empty   = (cnt_q == '0);
  assign full    = (cnt_q == CntW'(Depth));
  assign out_vld = !empty || in_vld;
  assign out_dat = empty ? in_dat : mem[rd_ptr_q];

  // An arrival into an empty FIFO that is taken straight away never touches storage.
  assign bypass = empty && in_vld && out_rdy;
  assign store  = in_vld && !bypass;
  assign deq    = out_rdy && !empty;

  function automatic logic [PtrW-1:0] ptr_next(input logic [PtrW-1:0] p);
    return (p == PtrW'(Depth - 1)) ? '0 : p + PtrW'(1);
  endfunction

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      if (store) wr_ptr_q <= ptr_next(wr_ptr_q);
      if (deq)   rd_ptr_q <= ptr_next(rd_ptr_q);
      case ({store, deq})
        2'b10:   cnt_q <= cnt_q + CntW'(1);
        2'b01:   cnt_q <= cnt_q - CntW'(1);
        default: cnt_q <= cnt_q;
      endcase
    end
  end

  // Storage needs no reset: the pointers alone decide what is valid.
  always_ff @(posedge clk_i) begin
    if (store) mem[wr_ptr_q] <= in_dat;
  end

  a_no_overflow: assert property (@(posedge clk_i) disable iff (!rst_ni) !(in_vld && full))
    else $error("tc_sram_initiator_fifo: push while full");

endmodule

// File: rtl/tc_sram_initiator.sv
// Valid/ready request port onto a fixed-latency SRAM, with credit-limited read responses.
// Latency: SRAM request is combinational; read response appears Latency cycles after acceptance.
// Backpressure: rsp_ready_i low fills the response buffer; req_ready_o drops once RspDepth reads are outstanding.
// Ports: clk_i/rst_ni clock and async active-low reset; req_* request channel; rsp_* read
//        response channel; sram_* SRAM macro interface, sram_rdata_i valid Latency cycles after a read.
module tc_sram_initiator import tc_sram_pkg::*; #(
  parameter int unsigned NumWords  = 1024,
  parameter int unsigned DataWidth = 32,
  parameter int unsigned ByteWidth = 8,
  parameter int unsigned Latency   = 1,
  parameter int unsigned RspDepth  = 2,
  parameter int unsigned AddrWidth = addr_width(NumWords),
  parameter int unsigned BeWidth   = (DataWidth + ByteWidth - 1) / ByteWidth
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 req_valid_i,
  output logic                 req_ready_o,
  input  logic                 req_we_i,
  input  logic [AddrWidth-1:0] req_addr_i,
  input  logic [DataWidth-1:0] req_wdata_i,
  input  logic [BeWidth-1:0]   req_be_i,
  output logic                 rsp_valid_o,
  input  logic                 rsp_ready_i,
  output logic [DataWidth-1:0] rsp_rdata_o,
  output logic                 rsp_err_o,
  output logic                 sram_req_o,
  output logic                 sram_we_o,
  output logic [AddrWidth-1:0] sram_addr_o,
  output logic [DataWidth-1:0] sram_wdata_o,
  output logic [BeWidth-1:0]   sram_be_o,
  input  logic [DataWidth-1:0] sram_rdata_i
);

  localparam int unsigned CntW = $clog2(RspDepth + 1);

  logic [CntW-1:0]    credit_q;
  logic               accept;
  logic               accept_rd;
  logic               in_range;
  logic               pop;
  logic [Latency-1:0] stg_vld_q;
  logic [Latency-1:0] stg_err_q;
  rsp_t               push_dat;
  rsp_t               rsp_dat;
  logic               push_vld;
  logic               fifo_full;
  logic               unused_rdata;

  // Requests are not taken while reset is held, even though ready reads high.
  assign in_range  = (64'(req_addr_i) < 64'(NumWords));
  assign accept    = rst_ni && req_valid_i && req_ready_o;
  assign accept_rd = accept && !req_we_i;

  assign sram_req_o   = accept && in_range;
  assign sram_we_o    = req_we_i;
  assign sram_addr_o  = req_addr_i;
  assign sram_wdata_o = req_wdata_i;
  assign sram_be_o    = req_be_i;

  // A pop frees its credit in the same cycle, so a full pipe keeps one read per cycle flowing.
  assign pop         = rsp_valid_o && rsp_ready_i;
  assign req_ready_o = (credit_q < CntW'(RspDepth)) || pop;

  // Credits cover reads in the shift register plus responses in the buffer.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      credit_q <= '0;
    end else begin
      case ({accept_rd, pop})
        2'b10:   credit_q <= credit_q + CntW'(1);
        2'b01:   credit_q <= credit_q - CntW'(1);
        default: credit_q <= credit_q;
      endcase
    end
  end

  // Stage Latency-1 lines up with the cycle the SRAM drives the matching read data.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      stg_vld_q <= '0;
      stg_err_q <= '0;
    end else begin
      stg_vld_q[0] <= accept_rd;
      stg_err_q[0] <= accept_rd && !in_range;
      for (int i = 1; i < int'(Latency); i++) begin
        stg_vld_q[i] <= stg_vld_q[i-1];
        stg_err_q[i] <= stg_err_q[i-1];
      end
    end
  end

  // Out-of-range reads never reached the SRAM, so its data bus is meaningless for them.
  assign push_vld       = stg_vld_q[Latency-1];
  assign push_dat.err   = stg_err_q[Latency-1];
  assign push_dat.rdata = stg_err_q[Latency-1] ? '0 : RspMaxWidth'(sram_rdata_i);

  tc_sram_initiator_fifo #(
    .Depth (RspDepth),
    .T     (rsp_t)
  ) u_rsp_fifo (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .in_vld  (push_vld),
    .in_dat  (push_dat),
    .out_vld (rsp_valid_o),
    .out_rdy (rsp_ready_i),
    .out_dat (rsp_dat),
    .full    (fifo_full)
  );

  assign rsp_rdata_o = rsp_dat.rdata[DataWidth-1:0];
  assign rsp_err_o   = rsp_dat.err;

  // Upper bits of the shared response width are always zero here.
  assign unused_rdata = ^rsp_dat.rdata ^ fifo_full;

  a_latency_min: assert property (@(posedge clk_i) Latency >= 1)
    else $error("tc_sram_initiator: Latency must be at least 1");
  a_depth_min: assert property (@(posedge clk_i) RspDepth >= Latency)
    else $error("tc_sram_initiator: RspDepth must be at least Latency");
  a_data_width: assert property (@(posedge clk_i) DataWidth <= RspMaxWidth)
    else $error("tc_sram_initiator: DataWidth exceeds response buffer width");
  a_credit_range: assert property (@(posedge clk_i) disable iff (!rst_ni) credit_q <= CntW'(RspDepth))
    else $error("tc_sram_initiator: credit counter out of range");

endmodule

// File: tb/tb_tc_sram_initiator.sv
// Bench for tc_sram_initiator with a behavioural SRAM and a queue-based reference model.
module tb_tc_sram_initiator;

  localparam int NW  = 16;
  localparam int DW  = 32;
  localparam int BW  = 4;
  localparam int LAT = 2;
  localparam int DEP = 2;
  localparam int AW  = 5;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          req_valid, req_ready, req_we;
  logic [AW-1:0] req_addr;
  logic [DW-1:0] req_wdata;
  logic [BW-1:0] req_be;
  logic          rsp_valid, rsp_ready, rsp_err;
  logic [DW-1:0] rsp_rdata;
  logic          sram_req, sram_we;
  logic [AW-1:0] sram_addr;
  logic [DW-1:0] sram_wdata, sram_rdata;
  logic [BW-1:0] sram_be;
  logic          rsp_ready_dir, rsp_rand_en, rsp_rand_bit;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  assign rsp_ready = rsp_rand_en ? rsp_rand_bit : rsp_ready_dir;

  tc_sram_initiator #(
    .NumWords(NW), .DataWidth(DW), .ByteWidth(8), .Latency(LAT), .RspDepth(DEP), .AddrWidth(AW)
  ) dut (
    .clk_i(clk), .rst_ni(rst_n),
    .req_valid_i(req_valid), .req_ready_o(req_ready), .req_we_i(req_we),
    .req_addr_i(req_addr), .req_wdata_i(req_wdata), .req_be_i(req_be),
    .rsp_valid_o(rsp_valid), .rsp_ready_i(rsp_ready), .rsp_rdata_o(rsp_rdata), .rsp_err_o(rsp_err),
    .sram_req_o(sram_req), .sram_we_o(sram_we), .sram_addr_o(sram_addr),
    .sram_wdata_o(sram_wdata), .sram_be_o(sram_be), .sram_rdata_i(sram_rdata)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Behavioural SRAM: byte-enabled writes, reads delivered LAT cycles later,
  // random garbage on the data bus whenever no read is due.
  logic [DW-1:0] sram_mem [NW];
  logic [DW-1:0] rd_pipe  [LAT];
  assign sram_rdata = rd_pipe[LAT-1];

  always @(posedge clk) begin
    rd_pipe[0] <= $urandom();
    for (int i = 1; i < LAT; i++) rd_pipe[i] <= rd_pipe[i-1];
    if (!rst_n) begin
      for (int i = 0; i < NW; i++) sram_mem[i] <= '0;
    end else if (sram_req) begin
      if (sram_we) begin
        for (int b = 0; b < BW; b++)
          if (sram_be[b]) sram_mem[sram_addr[3:0]][b*8 +: 8] <= sram_wdata[b*8 +: 8];
      end else begin
        rd_pipe[0] <= sram_mem[sram_addr[3:0]];
      end
    end
  end

  always begin
    @(posedge clk);
    #1 rsp_rand_bit = 1'($urandom_range(0, 1));
  end

  // Reference model: word array plus a queue of expected responses in acceptance order.
  typedef struct {
    logic [DW-1:0] d;
    logic          e;
    int            cyc;
  } exp_t;

  exp_t          q[$];
  logic [DW-1:0] ref_mem [NW];
  int            cyc = 0;
  int            acc_cnt = 0, pop_cnt = 0, ready_low_cnt = 0, sram_req_cnt = 0;
  logic [DW-1:0] last_rdata = '0;
  logic          last_err = 1'b0;
  logic          prev_hold = 1'b0;
  logic [DW-1:0] prev_d = '0;
  logic          prev_e = 1'b0;

  always @(negedge clk) begin
    cyc++;
    if (!rst_n) begin
      q.delete();
      for (int i = 0; i < NW; i++) ref_mem[i] = '0;
      prev_hold = 1'b0;
      chk("rst_rsp_valid", 64'(rsp_valid), 64'd0);
      chk("rst_sram_req",  64'(sram_req),  64'd0);
      chk("rst_req_ready", 64'(req_ready), 64'd1);
    end else begin
      logic acc, pop, inr;
      acc = req_valid && req_ready;
      pop = rsp_valid && rsp_ready;
      inr = (int'(req_addr) < NW);
      if (!req_ready) ready_low_cnt++;
      if (sram_req) sram_req_cnt++;
      chk("req_ready", 64'(req_ready), 64'((q.size() < DEP) || pop));
      chk("sram_req",  64'(sram_req),  64'(acc && inr));
      if (sram_req)
        chk("sram_fields", 64'({sram_we, sram_addr, sram_wdata, sram_be}),
            64'({req_we, req_addr, req_wdata, req_be}));
      if (prev_hold)
        chk("rsp_hold", 64'({rsp_valid, rsp_err, rsp_rdata}), 64'({1'b1, prev_e, prev_d}));
      if (rsp_valid) chk("rsp_spurious", 64'(q.size() > 0), 64'd1);
      if (pop && q.size() > 0) begin
        exp_t e;
        e = q.pop_front();
        pop_cnt++;
        last_rdata = rsp_rdata;
        last_err   = rsp_err;
        chk("rsp_rdata", 64'(rsp_rdata), 64'(e.d));
        chk("rsp_err",   64'(rsp_err),   64'(e.e));
        chk("rsp_early", 64'((cyc - e.cyc) >= LAT), 64'd1);
      end
      prev_hold = rsp_valid && !rsp_ready;
      prev_d    = rsp_rdata;
      prev_e    = rsp_err;
      if (acc) begin
        acc_cnt++;
        if (req_we) begin
          if (inr)
            for (int b = 0; b < BW; b++)
              if (req_be[b]) ref_mem[req_addr[3:0]][b*8 +: 8] = req_wdata[b*8 +: 8];
        end else begin
          q.push_back('{inr ? ref_mem[req_addr[3:0]] : '0, !inr, cyc});
        end
      end
    end
  end

  // Called at posedge+1; returns at posedge+1 right after the accepting edge.
  task automatic send(input logic we, input logic [AW-1:0] a, input logic [DW-1:0] d,
                      input logic [BW-1:0] be);
    logic ok;
    ok = 1'b0;
    req_valid = 1'b1; req_we = we; req_addr = a; req_wdata = d; req_be = be;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      ok = req_ready;
      @(posedge clk);
      #1;
      if (ok) break;
    end
    req_valid = 1'b0;
    chk("send_accept", 64'(ok), 64'd1);
  endtask

  task automatic drain();
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (q.size() == 0 && !rsp_valid) break;
    end
    chk("drain", 64'(q.size()), 64'd0);
    @(posedge clk);
    #1;
  endtask

  initial begin
    int base, base2, c0, n_reads;
    logic hit;

    rst_n = 1'b0; req_valid = 1'b0; req_we = 1'b0; req_addr = '0; req_wdata = '0; req_be = '0;
    rsp_ready_dir = 1'b1; rsp_rand_en = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Full write then read: response exactly LAT cycles after acceptance.
    send(1'b1, 5'd3, 32'hDEADBEEF, 4'hF);
    send(1'b0, 5'd3, '0, '0);
    @(negedge clk);
    chk("lat_cycle1_valid", 64'(rsp_valid), 64'd0);
    @(negedge clk);
    chk("lat_cycle2_valid", 64'(rsp_valid), 64'd1);
    chk("lat_cycle2_rdata", 64'(rsp_rdata), 64'hDEADBEEF);
    chk("lat_cycle2_err",   64'(rsp_err),   64'd0);
    @(posedge clk);
    #1;
    drain();

    // Partial byte write merges with the existing word.
    send(1'b1, 5'd5, 32'h11223344, 4'hF);
    send(1'b1, 5'd5, 32'h000000AA, 4'h1);
    send(1'b0, 5'd5, '0, '0);
    drain();
    chk("be_merge", 64'(last_rdata), 64'h112233AA);

    // Back-to-back reads of 0..7 with responses always accepted.
    for (int i = 0; i < 8; i++) send(1'b1, AW'(i), $urandom(), 4'hF);
    base = ready_low_cnt; base2 = pop_cnt; c0 = cyc;
    for (int i = 0; i < 8; i++) send(1'b0, AW'(i), '0, '0);
    chk("b2b_cycles", 64'(cyc - c0), 64'd8);
    chk("b2b_ready_low", 64'(ready_low_cnt - base), 64'd0);
    drain();
    chk("b2b_rsp_count", 64'(pop_cnt - base2), 64'd8);

    // Responses stalled: only DEP reads fit, then the request side blocks.
    rsp_ready_dir = 1'b0;
    base = acc_cnt; base2 = pop_cnt;
    req_valid = 1'b1; req_we = 1'b0; req_addr = 5'd8;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      hit = req_ready;
      @(posedge clk);
      #1;
      if (hit) req_addr = req_addr + 5'd1;
    end
    @(negedge clk);
    chk("stall_accepts", 64'(acc_cnt - base), 64'd2);
    chk("stall_ready",   64'(req_ready), 64'd0);
    chk("stall_rsp_valid", 64'(rsp_valid), 64'd1);
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    rsp_ready_dir = 1'b1;
    drain();
    chk("stall_rsp_count", 64'(pop_cnt - base2), 64'd2);

    // Out-of-range write is dropped, out-of-range read returns an error with zero data.
    base = sram_req_cnt; base2 = pop_cnt;
    send(1'b1, 5'd20, 32'hCAFEF00D, 4'hF);
    send(1'b0, 5'd20, '0, '0);
    drain();
    chk("oor_sram_req", 64'(sram_req_cnt - base), 64'd0);
    chk("oor_rsp_count", 64'(pop_cnt - base2), 64'd1);
    chk("oor_err",   64'(last_err),   64'd1);
    chk("oor_rdata", 64'(last_rdata), 64'd0);

    // Reset with two reads in flight: nothing may come out afterwards.
    send(1'b0, 5'd1, '0, '0);
    send(1'b0, 5'd2, '0, '0);
    rst_n = 1'b0;
    req_valid = 1'b1; req_we = 1'b0; req_addr = 5'd4;
    repeat (2) @(posedge clk);
    #1;
    req_valid = 1'b0;
    rst_n = 1'b1;
    base2 = pop_cnt;
    @(negedge clk);
    chk("post_rst_credit", 64'(dut.credit_q), 64'd0);
    chk("post_rst_rsp_valid", 64'(rsp_valid), 64'd0);
    repeat (6) @(posedge clk);
    #1;
    chk("post_rst_no_stale", 64'(pop_cnt - base2), 64'd0);

    // Random mix with random response backpressure.
    rsp_rand_en = 1'b1;
    base2 = pop_cnt; n_reads = 0;
    for (int n = 0; n < 300; n++) begin
      logic we;
      we = 1'($urandom_range(0, 1));
      if (!we) n_reads++;
      repeat ($urandom_range(0, 2)) begin
        @(posedge clk);
        #1;
      end
      send(we, AW'($urandom_range(0, 19)), $urandom(), BW'($urandom_range(0, 15)));
    end
    rsp_rand_en = 1'b0;
    rsp_ready_dir = 1'b1;
    drain();
    chk("rand_rsp_count", 64'(pop_cnt - base2), 64'(n_reads));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/tc_sram_initiator.md
TC_SRAM_INITIATOR -- requirements
Module: tc_sram_initiator

Interface
REQ-001 Parameters SHALL be, one per line: name, default, meaning:
- NumWords, 1024, words in the attached SRAM
- DataWidth, 32, data width
- ByteWidth, 8, byte width
- Latency, 1, SRAM read latency in cycles, must be at least 1
- RspDepth, 2, response buffer entries, must be at least Latency
- AddrWidth, derived: clog2(NumWords), or 1 when NumWords is 1
- BeWidth, derived: ceil(DataWidth/ByteWidth)
REQ-002 Ports SHALL be, one per line: name, direction, width, meaning:
- clk_i, in, 1, single clock
- rst_ni, in, 1, reset; asynchronous, active-low
- req_valid_i, in, 1, request valid
- req_ready_o, out, 1, request ready
- req_we_i, in, 1, write request
- req_addr_i, in, AddrWidth, word address
- req_wdata_i, in, DataWidth, write data
- req_be_i, in, BeWidth, byte enables
- rsp_valid_o, out, 1, read response valid
- rsp_ready_i, in, 1, read response ready
- rsp_rdata_o, out, DataWidth, read data
- rsp_err_o, out, 1, address out of range
- sram_req_o, out, 1, SRAM request
- sram_we_o, out, 1, SRAM write enable
- sram_addr_o, out, AddrWidth, SRAM address
- sram_wdata_o, out, DataWidth, SRAM write data
- sram_be_o, out, BeWidth, SRAM byte enables
- sram_rdata_i, in, DataWidth, SRAM read data, valid Latency cycles after a read request

Function
REQ-003 A request SHALL be accepted in a cycle where req_valid_i and req_ready_o are both high.
REQ-004 sram_req_o SHALL equal accepted AND (req_addr_i < NumWords), combinationally, with no added latency.
REQ-005 sram_we_o, sram_addr_o, sram_wdata_o and sram_be_o SHALL pass through the request fields unchanged.
REQ-006 Accepted writes SHALL produce no response and SHALL not consume credits.
REQ-007 An accepted out-of-range write SHALL be silently dropped.
REQ-008 Every accepted read SHALL produce exactly one response, in acceptance order.
REQ-009 A credit counter SHALL track in-flight reads plus buffered responses, range 0..RspDepth, width clog2(RspDepth+1).
REQ-010 req_ready_o SHALL be high when the counter is below RspDepth, or when it equals RspDepth and a response pops in the same cycle; it SHALL not depend on req_we_i or req_valid_i.
REQ-011 The counter SHALL increment on an accepted read and decrement on a response pop; a simultaneous accept and pop SHALL leave it unchanged.
REQ-012 A Latency-stage shift register SHALL carry a valid bit and an error bit for each accepted read.
REQ-013 When a valid entry reaches the last stage, sram_rdata_i SHALL be captured into the response buffer in that cycle; for error entries the buffer SHALL receive all zeros instead.
REQ-014 The response buffer SHALL be a fall-through FIFO: when empty, an arriving response SHALL appear on rsp_valid_o/rsp_rdata_o in its arrival cycle, giving total read latency of Latency cycles.
REQ-015 rsp_valid_o, rsp_rdata_o and rsp_err_o SHALL hold stable while rsp_valid_o is high and rsp_ready_i is low.
REQ-016 FIFO overflow SHALL be impossible by construction; an assertion SHALL flag any push while the FIFO is full.
REQ-017 The block SHALL sustain one read per cycle when rsp_ready_i is held high and RspDepth is at least Latency.

Reset
REQ-018 While rst_ni is low, rsp_valid_o SHALL be 0, sram_req_o SHALL be 0, and req_ready_o SHALL be 1.
REQ-019 Reset SHALL clear the credit counter, all shift-register valid bits and the FIFO pointers.
REQ-020 Reads in flight or buffered when reset asserts SHALL be discarded; no response SHALL appear after reset deasserts.

Structure
REQ-021 Package tc_sram_pkg SHALL hold the address-width function and the response struct (rdata, err).
REQ-022 The response FIFO SHALL be the sub-module tc_sram_initiator_fifo (fall-through, parameterised depth and type).
REQ-023 Parameter checks (Latency at least 1, RspDepth at least Latency) SHALL be simulation-only assertions.

Verification
Bench configuration: NumWords=16, DataWidth=32, Latency=2, RspDepth=2, driving a behavioural tc_sram.
REQ-024 Write 0xDEADBEEF to address 3 with be=0xF, then read address 3 -> one response 0xDEADBEEF with err=0, exactly 2 cycles after acceptance.
REQ-025 Write with be=0x1, data 0x000000AA, onto a word holding 0x11223344, then read it -> 0x112233AA.
REQ-026 Back-to-back reads of addresses 0..7 with rsp_ready_i held high -> 8 in-order responses, req_ready_o never low.
REQ-027 rsp_ready_i held low, read stream issued -> exactly 2 reads accepted, then req_ready_o=0; rsp_ready_i raised -> data in order, no loss.
REQ-028 Read at address 20 -> sram_req_o stays 0, response arrives with err=1 and data 0x00000000.
REQ-029 rst_ni pulsed low with 2 reads in flight -> rsp_valid_o=0 and credit counter 0 after reset, no stale response.
